// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite animation mapper
package sprite_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} anim_state_t;
    localparam int TRANSPARENT_IDX = 0;
    localparam int COLOR_W = 4;
    localparam int IDX_W = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
endpackage

// File: rtl/sprite_frame_rom.sv
// sprite_frame_rom: all animation frames stored contiguously, registered read with 1-cycle latency
// vga_clk: clock; address: frame*W*H + row*W + col; q: palette index of that pixel
module sprite_frame_rom
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 66,
    parameter int NUM_FRAMES = 4,
    parameter int ADDR_W = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H)
) (
    input  logic              vga_clk,
    input  logic [ADDR_W-1:0] address,
    output logic [IDX_W-1:0]  q
);
    localparam int DEPTH = NUM_FRAMES * SPRITE_W * SPRITE_H;
    // Frame art: each pixel holds (frame + col) mod 16, built at elaboration
    function automatic logic [DEPTH*IDX_W-1:0] init_rom();
        logic [DEPTH*IDX_W-1:0] v;
        v = '0;
        for (int f = 0; f < NUM_FRAMES; f++)
            for (int r = 0; r < SPRITE_H; r++)
                for (int c = 0; c < SPRITE_W; c++)
                    v[((f * SPRITE_H + r) * SPRITE_W + c) * IDX_W +: IDX_W] = IDX_W'(f + c);
        return v;
    endfunction
    localparam logic [DEPTH*IDX_W-1:0] CONTENTS = init_rom();
    // Off-sprite addresses can exceed the array; they read as transparent
    always_ff @(posedge vga_clk)
        q <= (32'(address) < DEPTH) ? CONTENTS[32'(address) * IDX_W +: IDX_W] : '0;
endmodule

// File: rtl/sprite_anim_mapper.sv
// sprite_anim_mapper: maps the beam position onto an animated, optionally mirrored/scaled sprite
// Inputs: vga_clk, reset, DrawX/DrawY/blank beam, sprite_x/sprite_y origin, frame_tick, anim_en, oneshot, mirror
// Outputs: red/green/blue, sprite_on (2 cycles after the pixel), frame_idx, anim_done
module sprite_anim_mapper
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 40,
    parameter int SPRITE_H = 66,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD = 3,
    parameter int SCALE_LOG2 = 0
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          blank,
    input  logic [9:0]                    sprite_x,
    input  logic [9:0]                    sprite_y,
    input  logic                          frame_tick,
    input  logic                          anim_en,
    input  logic                          oneshot,
    input  logic                          mirror,
    output logic [COLOR_W-1:0]            red,
    output logic [COLOR_W-1:0]            green,
    output logic [COLOR_W-1:0]            blue,
    output logic                          sprite_on,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          anim_done
);
    localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
    localparam int ADDR_W = $clog2(NUM_FRAMES * FRAME_SZ);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic [10:0] BOX_W = 11'(SPRITE_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(SPRITE_H << SCALE_LOG2);

    function automatic logic [3*COLOR_W-1:0] palette(input logic [IDX_W-1:0] i);
        return {i, ~i, i[1:0], i[3:2]};
    endfunction

    anim_state_t state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [HW-1:0] hold_q, hold_d;
    logic hit_q, hit_d, blank_q, blank_d, on_q, on_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;
    logic [10:0] dx, dy;
    logic [9:0] col, row, col_m;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0] rom_q;

    // Box compare in 11 bits so the far edge never wraps past 1023
    always_comb begin
        dx = {1'b0, DrawX} - {1'b0, sprite_x};
        dy = {1'b0, DrawY} - {1'b0, sprite_y};
        hit_d = DrawX >= sprite_x && DrawY >= sprite_y &&
                {1'b0, DrawX} < {1'b0, sprite_x} + BOX_W &&
                {1'b0, DrawY} < {1'b0, sprite_y} + BOX_H;
        blank_d = blank;
        col = 10'(dx >> SCALE_LOG2);
        row = 10'(dy >> SCALE_LOG2);
        col_m = mirror ? 10'(SPRITE_W - 1) - col : col;
        addr = ADDR_W'(32'(frame_q) * FRAME_SZ + 32'(row) * SPRITE_W + 32'(col_m));
    end

    sprite_frame_rom #(
        .SPRITE_W(SPRITE_W),
        .SPRITE_H(SPRITE_H),
        .NUM_FRAMES(NUM_FRAMES),
        .ADDR_W(ADDR_W)
    ) u_rom (
        .vga_clk(vga_clk),
        .address(addr),
        .q(rom_q)
    );

    always_comb begin
        on_d = hit_q && blank_q && rom_q != IDX_W'(TRANSPARENT_IDX);
        rgb_d = on_d ? palette(rom_q) : '0;
    end

    // The frame counter only moves on frame_tick, so a frame never changes mid-picture
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d = hold_q;
        if (frame_tick) begin
            if (!anim_en) begin
                state_d = IDLE;
                frame_d = '0;
                hold_d = '0;
            end else if (state_q == IDLE) begin
                state_d = RUN;
            end else if (state_q == RUN) begin
                if (hold_q == HW'(HOLD - 1)) begin
                    hold_d = '0;
                    if (frame_q == FW'(NUM_FRAMES - 1)) begin
                        state_d = oneshot ? DONE : RUN;
                        frame_d = oneshot ? frame_q : '0;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q <= '0;
            hit_q <= 1'b0;
            blank_q <= 1'b0;
            on_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q <= hold_d;
            hit_q <= hit_d;
            blank_q <= blank_d;
            on_q <= on_d;
            rgb_q <= rgb_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign sprite_on = on_q;
    assign frame_idx = frame_q;
    assign anim_done = state_q == DONE;
endmodule

// File: tb/tb_sprite_anim_mapper.sv
// tb_sprite_anim_mapper: directed tables, hand sequences and random traffic against a behavioural model
module tb_sprite_anim_mapper;
    localparam int NF = 4;
    localparam int HOLDN = 3;
    localparam int NR = 3000;

    logic vga_clk = 1'b0;
    logic reset, blank, frame_tick, anim_en, oneshot, mirror;
    logic [9:0] DrawX, DrawY, sprite_x, sprite_y;
    logic [3:0] red0, green0, blue0, red1, green1, blue1;
    logic sprite_on0, sprite_on1, anim_done0, anim_done1;
    logic [1:0] frame_idx0, frame_idx1;

    always #5 vga_clk = ~vga_clk;

    sprite_anim_mapper dut0 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_tick(frame_tick), .anim_en(anim_en),
        .oneshot(oneshot), .mirror(mirror), .red(red0), .green(green0), .blue(blue0),
        .sprite_on(sprite_on0), .frame_idx(frame_idx0), .anim_done(anim_done0)
    );

    sprite_anim_mapper #(.SCALE_LOG2(1)) dut1 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_tick(frame_tick), .anim_en(anim_en),
        .oneshot(oneshot), .mirror(mirror), .red(red1), .green(green1), .blue(blue1),
        .sprite_on(sprite_on1), .frame_idx(frame_idx1), .anim_done(anim_done1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int pal(input int i);
        return (i << 8) | ((15 - i) << 4) | ((i % 4) * 4 + i / 4);
    endfunction

    function automatic int pix_of(input int on, input int idx);
        return on != 0 ? ((1 << 12) | pal(idx)) : 0;
    endfunction

    // Expected pixel straight from the picture rules: art index is (frame + col) mod 16
    function automatic int ref_pix(input int dx, input int dy, input int sx, input int sy,
                                   input int mir, input int blk, input int frame, input int sc);
        int w, h, col, idx;
        w = 40 << sc;
        h = 66 << sc;
        if (blk == 0 || dx < sx || dx >= sx + w || dy < sy || dy >= sy + h) return 0;
        col = (dx - sx) >> sc;
        if (mir != 0) col = 39 - col;
        idx = (frame + col) % 16;
        return idx == 0 ? 0 : ((1 << 12) | pal(idx));
    endfunction

    function automatic int pix0();
        return int'({sprite_on0, red0, green0, blue0});
    endfunction

    function automatic int pix1();
        return int'({sprite_on1, red1, green1, blue1});
    endfunction

    task automatic drive_pix(input int dx, input int dy, input int sx, input int sy,
                             input int mir, input int blk);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        sprite_x = 10'(sx);
        sprite_y = 10'(sy);
        mirror = mir[0];
        blank = blk[0];
    endtask

    task automatic tick(input logic en, input logic os);
        anim_en = en;
        oneshot = os;
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        @(negedge vga_clk);
    endtask

    typedef struct {
        int dx, dy, sx, sy, mir, blk, on0, i0, on1, i1;
    } vec_t;
    vec_t tv[16];
    int seq3[13];

    int e0[NR];
    int e1[NR];
    int ms, mt, mframe;
    int sx, sy, dx, dy, mir, blk;
    logic rst_v, tick_v;

    initial begin
        tv[0]  = '{105, 60, 100, 50, 0, 1, 1, 5, 1, 2};
        tv[1]  = '{139, 60, 100, 50, 0, 1, 1, 7, 1, 3};
        tv[2]  = '{140, 60, 100, 50, 0, 1, 0, 0, 1, 4};
        tv[3]  = '{100, 60, 100, 50, 0, 1, 0, 0, 0, 0};
        tv[4]  = '{100, 60, 100, 50, 1, 1, 1, 7, 1, 7};
        tv[5]  = '{101, 60, 100, 50, 1, 1, 1, 6, 1, 7};
        tv[6]  = '{139, 60, 100, 50, 1, 1, 0, 0, 1, 4};
        tv[7]  = '{179, 60, 100, 50, 0, 1, 0, 0, 1, 7};
        tv[8]  = '{180, 60, 100, 50, 0, 1, 0, 0, 0, 0};
        tv[9]  = '{105, 60, 100, 50, 0, 0, 0, 0, 0, 0};
        tv[10] = '{105, 115, 100, 50, 0, 1, 1, 5, 1, 2};
        tv[11] = '{105, 116, 100, 50, 0, 1, 0, 0, 1, 2};
        tv[12] = '{99, 60, 100, 50, 0, 1, 0, 0, 0, 0};
        tv[13] = '{105, 49, 100, 50, 0, 1, 0, 0, 0, 0};
        tv[14] = '{1023, 410, 1000, 400, 0, 1, 1, 7, 1, 11};
        tv[15] = '{639, 479, 620, 450, 0, 1, 1, 3, 1, 9};
        seq3 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

        reset = 1'b1;
        frame_tick = 1'b0;
        anim_en = 1'b0;
        oneshot = 1'b0;
        drive_pix(0, 0, 100, 50, 0, 0);
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        chk("reset_pix", pix0(), 0);
        chk("reset_frame", int'(frame_idx0), 0);
        chk("reset_done", int'(anim_done0), 0);
        reset = 1'b0;
        repeat (2) @(negedge vga_clk);

        // Pixel latency: visible exactly two cycles after the sample
        drive_pix(105, 60, 100, 50, 0, 1);
        @(negedge vga_clk);
        drive_pix(105, 60, 100, 50, 0, 0);
        chk("lat_cycle1", pix0(), 0);
        @(negedge vga_clk);
        chk("lat_cycle2", pix0(), pix_of(1, 5));
        @(negedge vga_clk);
        chk("lat_cycle3", pix0(), 0);

        for (int i = 0; i < 16; i++) begin
            drive_pix(tv[i].dx, tv[i].dy, tv[i].sx, tv[i].sy, tv[i].mir, tv[i].blk);
            repeat (2) @(negedge vga_clk);
            chk($sformatf("vec%0d_scale0", i), pix0(), pix_of(tv[i].on0, tv[i].i0));
            chk($sformatf("vec%0d_scale1", i), pix1(), pix_of(tv[i].on1, tv[i].i1));
        end
        drive_pix(0, 0, 100, 50, 0, 0);

        for (int i = 0; i < 13; i++) begin
            tick(1'b1, 1'b0);
            chk($sformatf("loop_frame%0d", i), int'(frame_idx0), seq3[i]);
            chk($sformatf("loop_done%0d", i), int'(anim_done0), 0);
        end
        repeat (3) tick(1'b1, 1'b0);
        anim_en = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk("en_low_no_tick", int'(frame_idx0), 1);
        tick(1'b0, 1'b0);
        chk("en_low_tick", int'(frame_idx0), 0);

        tick(1'b1, 1'b1);
        for (int i = 0; i < 11; i++) tick(1'b1, 1'b1);
        chk("oneshot_pre_done", int'(anim_done0), 0);
        tick(1'b1, 1'b1);
        chk("oneshot_frame", int'(frame_idx0), 3);
        chk("oneshot_done", int'(anim_done0), 1);
        repeat (2) tick(1'b1, 1'b1);
        chk("done_hold_frame", int'(frame_idx0), 3);
        tick(1'b1, 1'b0);
        chk("done_oneshot_off", int'(anim_done0), 1);
        tick(1'b0, 1'b0);
        chk("done_exit_frame", int'(frame_idx0), 0);
        chk("done_exit_flag", int'(anim_done0), 0);

        // Reset in RUN at frame 2, together with frame_tick
        repeat (7) tick(1'b1, 1'b0);
        chk("pre_reset_frame", int'(frame_idx0), 2);
        drive_pix(105, 60, 100, 50, 0, 1);
        repeat (2) @(negedge vga_clk);
        chk("pre_reset_pix", pix0(), pix_of(1, 7));
        reset = 1'b1;
        frame_tick = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        frame_tick = 1'b0;
        chk("rst_frame", int'(frame_idx0), 0);
        chk("rst_done", int'(anim_done0), 0);
        chk("rst_pix", pix0(), 0);
        @(negedge vga_clk);
        chk("rst_release1", pix0(), 0);
        @(negedge vga_clk);
        chk("rst_release2", pix0(), pix_of(1, 5));
        chk("rst_state_idle", int'(frame_idx0), 0);

        ms = 0;
        mt = 0;
        anim_en = 1'b1;
        oneshot = 1'b0;
        for (int c = 0; c < NR; c++) begin
            if (c >= 2) begin
                chk($sformatf("rnd_pix0_c%0d", c), pix0(), e0[c-2]);
                chk($sformatf("rnd_pix1_c%0d", c), pix1(), e1[c-2]);
            end
            mframe = ms == 0 ? 0 : (mt / HOLDN) % NF;
            if (c >= 1) begin
                chk($sformatf("rnd_frame_c%0d", c), int'(frame_idx0), mframe);
                chk($sformatf("rnd_done_c%0d", c), int'(anim_done0), ms == 2 ? 1 : 0);
                chk($sformatf("rnd_frame1_c%0d", c), int'(frame_idx1), mframe);
            end
            rst_v = (c == 0) || ($urandom_range(0, 299) == 0);
            tick_v = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 63) == 0) anim_en = ~anim_en;
            if ($urandom_range(0, 31) == 0) oneshot = ~oneshot;
            sx = $urandom_range(0, 1000);
            sy = $urandom_range(0, 1000);
            dx = sx + $urandom_range(0, 180) - 10;
            dy = sy + $urandom_range(0, 150) - 10;
            dx = dx < 0 ? 0 : (dx > 1023 ? 1023 : dx);
            dy = dy < 0 ? 0 : (dy > 1023 ? 1023 : dy);
            mir = $urandom_range(0, 1);
            blk = $urandom_range(0, 7) != 0 ? 1 : 0;
            drive_pix(dx, dy, sx, sy, mir, blk);
            reset = rst_v;
            frame_tick = tick_v;
            e0[c] = rst_v ? 0 : ref_pix(dx, dy, sx, sy, mir, blk, mframe, 0);
            e1[c] = rst_v ? 0 : ref_pix(dx, dy, sx, sy, mir, blk, mframe, 1);
            if (rst_v && c >= 1) begin
                e0[c-1] = 0;
                e1[c-1] = 0;
            end
            @(posedge vga_clk);
            if (rst_v) begin
                ms = 0;
                mt = 0;
            end else if (tick_v) begin
                if (!anim_en) begin
                    ms = 0;
                    mt = 0;
                end else if (ms == 0) begin
                    ms = 1;
                    mt = 0;
                end else if (ms == 1) begin
                    mt++;
                    if (mt == NF * HOLDN) begin
                        if (oneshot) begin
                            ms = 2;
                            mt = NF * HOLDN - 1;
                        end else begin
                            mt = 0;
                        end
                    end
                end
            end
            @(negedge vga_clk);
        end
        reset = 1'b0;
        frame_tick = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
